// File: rtl/pattern_search_pkg.sv
// ---------------------------------------------------------------------------
// pattern_search_pkg
//
// Shared definitions for the pattern stream searcher:
//   BIT_PER_SYMB  - bits per stream symbol
//   DATA_SYMB     - symbols per stream beat
//   PAT_SYMB      - key length in symbols
//   symbol_t      - one stream symbol
//   pkt_state_e   - packet framing state (outside / inside a packet)
//   sat_count()   - saturating helper for the window valid-symbol count
// ---------------------------------------------------------------------------
package pattern_search_pkg;

    localparam int BIT_PER_SYMB = 8;
    localparam int DATA_SYMB    = 64 / BIT_PER_SYMB;
    localparam int PAT_SYMB     = 12;

    typedef logic [BIT_PER_SYMB-1:0] symbol_t;

    typedef enum logic [0:0] {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_e;

    function automatic int sat_count(input int count, input int limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// ---------------------------------------------------------------------------
// pattern_window_cmp
//
// Purely combinational key matcher. The history window (oldest symbol at the
// MSB end) is concatenated with the current beat (first symbol at the MSB
// end) into one symbol stream. Every alignment that ends inside the beat is
// compared against the key; an alignment only counts when all of its stream
// positions are flagged valid in valid_mask.
//
// Ports:
//   window     in  (KEY_SYMB-1) symbols of history, oldest first
//   beat       in  NUM_LANES symbols of the current beat, first symbol at MSB
//   valid_mask in  one bit per stream position, bit 0 = oldest window symbol
//   key        in  KEY_SYMB symbols, symbol 0 at MSB
//   hit        out at least one fully valid alignment equals the key
// ---------------------------------------------------------------------------
module pattern_window_cmp
    import pattern_search_pkg::*;
#(
    parameter int NUM_LANES = DATA_SYMB,
    parameter int KEY_SYMB  = PAT_SYMB
) (
    input  logic [(KEY_SYMB-1)*BIT_PER_SYMB-1:0]   window,
    input  logic [NUM_LANES*BIT_PER_SYMB-1:0]      beat,
    input  logic [KEY_SYMB-1+NUM_LANES-1:0]        valid_mask,
    input  logic [KEY_SYMB*BIT_PER_SYMB-1:0]       key,
    output logic                                   hit
);

    localparam int TOT_SYMB = KEY_SYMB - 1 + NUM_LANES;

    logic [TOT_SYMB*BIT_PER_SYMB-1:0] stream;
    symbol_t                          stream_symb [TOT_SYMB];
    symbol_t                          key_symb    [KEY_SYMB];
    logic [NUM_LANES-1:0]             lane_hit;

    assign stream = {window, beat};

    genvar gi, gk;
    generate
        for (gi = 0; gi < TOT_SYMB; gi++) begin : g_stream
            assign stream_symb[gi] = stream[(TOT_SYMB-gi)*BIT_PER_SYMB-1 -: BIT_PER_SYMB];
        end

        for (gi = 0; gi < KEY_SYMB; gi++) begin : g_key
            assign key_symb[gi] = key[(KEY_SYMB-gi)*BIT_PER_SYMB-1 -: BIT_PER_SYMB];
        end

        // Alignment gi covers stream positions gi .. gi+KEY_SYMB-1, i.e. it
        // ends on beat lane gi.
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [KEY_SYMB-1:0] symb_ok;
            for (gk = 0; gk < KEY_SYMB; gk++) begin : g_symb
                assign symb_ok[gk] = valid_mask[gi+gk] &&
                                     (stream_symb[gi+gk] == key_symb[gk]);
            end
            assign lane_hit[gi] = &symb_ok;
        end
    endgenerate

    assign hit = |lane_hit;

endmodule

// File: rtl/pattern_stream_searcher.sv
// ---------------------------------------------------------------------------
// pattern_stream_searcher
//
// Avalon-ST pass-through stage (one register stage) that searches every
// packet for a PAT_SYMB-symbol key, including occurrences spanning beats,
// and reports one verdict per packet together with the outgoing EOP beat.
//
// Ports:
//   clk_i, srst_n_i        clock, synchronous active-low reset
//   pattern_i, en_i        key and enable, captured on the SOP beat
//   snk_*                  Avalon-ST sink (data, valid, sop, eop, empty, ready)
//   src_*                  Avalon-ST source, registered copy of the sink
//   res_valid_o            verdict strobe, with the accepted source EOP beat
//   res_match_o            verdict value: key found in the packet
//   match_cnt_o            (SEARCH_MATCH_CNT_EN only) count of matching verdicts
//
// Build option: define SEARCH_MATCH_CNT_EN to add the 32-bit match counter.
// ---------------------------------------------------------------------------
module pattern_stream_searcher
    import pattern_search_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BIT_PER_SYMB = 8,
    parameter int PAT_SYMB     = 12,
    parameter int EMPTY_WIDTH  = 3
) (
    input  logic                             clk_i,
    input  logic                             srst_n_i,
    input  logic [PAT_SYMB*BIT_PER_SYMB-1:0] pattern_i,
    input  logic                             en_i,
    input  logic [DATA_WIDTH-1:0]            snk_data_i,
    input  logic                             snk_valid_i,
    input  logic                             snk_startofpacket_i,
    input  logic                             snk_endofpacket_i,
    input  logic [EMPTY_WIDTH-1:0]           snk_empty_i,
    output logic                             snk_ready_o,
    output logic [DATA_WIDTH-1:0]            src_data_o,
    output logic                             src_valid_o,
    output logic                             src_startofpacket_o,
    output logic                             src_endofpacket_o,
    output logic [EMPTY_WIDTH-1:0]           src_empty_o,
    input  logic                             src_ready_i,
    output logic                             res_valid_o,
    output logic                             res_match_o
`ifdef SEARCH_MATCH_CNT_EN
    ,
    output logic [31:0]                      match_cnt_o
`endif
);

    localparam int LANES     = DATA_WIDTH / BIT_PER_SYMB;
    localparam int WIN_SYMB  = PAT_SYMB - 1;
    localparam int WIN_WIDTH = WIN_SYMB * BIT_PER_SYMB;
    localparam int KEY_WIDTH = PAT_SYMB * BIT_PER_SYMB;
    localparam int CNT_W     = $clog2(PAT_SYMB + 1);

    // Packet framing FSM
    pkt_state_e state_reg, state_next;

    // Source register stage
    logic [DATA_WIDTH-1:0]  src_data_reg;
    logic                   src_valid_reg;
    logic                   src_sop_reg;
    logic                   src_eop_reg;
    logic [EMPTY_WIDTH-1:0] src_empty_reg;
    logic                   verdict_reg;     // held beat closes a tracked packet
    logic                   res_match_reg;

    // Per-packet search state
    logic                   en_reg;
    logic [KEY_WIDTH-1:0]   pattern_reg;
    logic [WIN_WIDTH-1:0]   window_reg, window_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_eff, cnt_next;
    logic                   flag_reg, flag_prev;

    logic                   snk_fire;
    logic                   searched;
    logic                   en_eff;
    logic [KEY_WIDTH-1:0]   key_eff;
    logic [WIN_SYMB-1:0]    win_valid;
    logic [LANES-1:0]       lane_valid;
    logic [WIN_SYMB+LANES-1:0] valid_mask;
    logic                   hit_raw;
    logic                   hit;
    logic                   verdict_match;

    assign snk_ready_o = src_ready_i | ~src_valid_reg;
    assign snk_fire    = snk_valid_i & snk_ready_o;

    // A beat belongs to a packet if it opens one or arrives inside one;
    // stray beats outside a packet bypass the search entirely.
    assign searched = snk_startofpacket_i | (state_reg == PKT_BODY);

    // On the SOP beat the live key/enable apply; afterwards the captured copy.
    assign en_eff    = snk_startofpacket_i ? en_i      : en_reg;
    assign key_eff   = snk_startofpacket_i ? pattern_i : pattern_reg;
    assign cnt_eff   = snk_startofpacket_i ? '0        : cnt_reg;
    assign flag_prev = snk_startofpacket_i ? 1'b0      : flag_reg;

    genvar gi;
    generate
        // Window position gi (0 = oldest) holds a packet symbol only when at
        // least WIN_SYMB-gi symbols of this packet have been seen.
        for (gi = 0; gi < WIN_SYMB; gi++) begin : g_win_valid
            localparam logic [CNT_W-1:0] NEED = CNT_W'(WIN_SYMB - gi);
            assign win_valid[gi] = (cnt_eff >= NEED);
        end

        // Empty only trims trailing lanes of the EOP beat.
        for (gi = 0; gi < LANES; gi++) begin : g_lane_valid
            localparam logic [EMPTY_WIDTH:0] LANE_LIMIT = (EMPTY_WIDTH+1)'(LANES - gi);
            assign lane_valid[gi] = ~snk_endofpacket_i |
                                    ({1'b0, snk_empty_i} < LANE_LIMIT);
        end

        // Shift the beat into the window, keeping the newest WIN_SYMB symbols.
        if (WIN_WIDTH > DATA_WIDTH) begin : g_shift_long
            assign window_next = {window_reg[WIN_WIDTH-DATA_WIDTH-1:0], snk_data_i};
        end else begin : g_shift_short
            assign window_next = snk_data_i[WIN_WIDTH-1:0];
        end
    endgenerate

    assign valid_mask = {lane_valid, win_valid};
    assign cnt_next   = CNT_W'(sat_count(int'(cnt_eff) + LANES, PAT_SYMB));

    pattern_window_cmp #(
        .NUM_LANES (LANES),
        .KEY_SYMB  (PAT_SYMB)
    ) u_cmp (
        .window     (window_reg),
        .beat       (snk_data_i),
        .valid_mask (valid_mask),
        .key        (key_eff),
        .hit        (hit_raw)
    );

    assign hit           = hit_raw & en_eff & searched;
    assign verdict_match = flag_prev | hit;

    // Framing FSM: next state
    always_comb begin
        state_next = state_reg;
        if (snk_fire) begin
            if (snk_startofpacket_i) begin
                state_next = snk_endofpacket_i ? PKT_IDLE : PKT_BODY;
            end else if (snk_endofpacket_i) begin
                state_next = PKT_IDLE;
            end
        end
    end

    // Framing FSM: state register
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_reg <= PKT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and search state
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            src_data_reg  <= '0;
            src_valid_reg <= 1'b0;
            src_sop_reg   <= 1'b0;
            src_eop_reg   <= 1'b0;
            src_empty_reg <= '0;
            verdict_reg   <= 1'b0;
            res_match_reg <= 1'b0;
            en_reg        <= 1'b0;
            pattern_reg   <= '0;
            window_reg    <= '0;
            cnt_reg       <= '0;
            flag_reg      <= 1'b0;
        end else if (snk_fire) begin
            src_data_reg  <= snk_data_i;
            src_valid_reg <= 1'b1;
            src_sop_reg   <= snk_startofpacket_i;
            src_eop_reg   <= snk_endofpacket_i;
            src_empty_reg <= snk_empty_i;
            verdict_reg   <= snk_endofpacket_i & searched;
            res_match_reg <= snk_endofpacket_i & searched & verdict_match;
            if (snk_startofpacket_i) begin
                en_reg      <= en_i;
                pattern_reg <= pattern_i;
            end
            if (searched) begin
                window_reg <= window_next;
                cnt_reg    <= cnt_next;
                flag_reg   <= verdict_match;
            end
        end else if (src_ready_i) begin
            src_valid_reg <= 1'b0;
        end
    end

    assign src_data_o          = src_data_reg;
    assign src_valid_o         = src_valid_reg;
    assign src_startofpacket_o = src_sop_reg;
    assign src_endofpacket_o   = src_eop_reg;
    assign src_empty_o         = src_empty_reg;
    assign res_valid_o         = src_valid_reg & src_eop_reg & src_ready_i & verdict_reg;
    assign res_match_o         = res_match_reg;

`ifdef SEARCH_MATCH_CNT_EN
    logic [31:0] match_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            match_cnt_reg <= '0;
        end else if (res_valid_o & res_match_o) begin
            match_cnt_reg <= match_cnt_reg + 32'd1;
        end
    end

    assign match_cnt_o = match_cnt_reg;
`endif

endmodule

// File: tb/tb_pattern_stream_searcher.sv
// ---------------------------------------------------------------------------
// tb_pattern_stream_searcher
//
// Directed and randomized packets are driven into the searcher. A reference
// model predicts every outgoing beat (pass-through with one stage of delay)
// and the per-packet verdict by scanning the packet's valid symbols for the
// key. Build option SEARCH_MATCH_CNT_EN also checks the match counter.
// ---------------------------------------------------------------------------
module tb_pattern_stream_searcher;

    localparam int PAT   = 12;
    localparam int LANES = 8;

    logic         clk_i = 1'b0;
    logic         srst_n_i;
    logic [95:0]  pattern_i;
    logic         en_i;
    logic [63:0]  snk_data_i;
    logic         snk_valid_i;
    logic         snk_startofpacket_i;
    logic         snk_endofpacket_i;
    logic [2:0]   snk_empty_i;
    logic         snk_ready_o;
    logic [63:0]  src_data_o;
    logic         src_valid_o;
    logic         src_startofpacket_o;
    logic         src_endofpacket_o;
    logic [2:0]   src_empty_o;
    logic         src_ready_i;
    logic         res_valid_o;
    logic         res_match_o;
`ifdef SEARCH_MATCH_CNT_EN
    logic [31:0]  match_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    pattern_stream_searcher dut (
        .clk_i               (clk_i),
        .srst_n_i            (srst_n_i),
        .pattern_i           (pattern_i),
        .en_i                (en_i),
        .snk_data_i          (snk_data_i),
        .snk_valid_i         (snk_valid_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_empty_i         (snk_empty_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_valid_o         (src_valid_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_empty_o         (src_empty_o),
        .src_ready_i         (src_ready_i),
        .res_valid_o         (res_valid_o),
        .res_match_o         (res_match_o)
`ifdef SEARCH_MATCH_CNT_EN
        ,
        .match_cnt_o         (match_cnt_o)
`endif
    );

    typedef byte bq_t[$];
    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        bit          verdict;
        bit          match;
    } beat_t;

    beat_t  exp_q[$];
    bit     exp_v[$];
    bit     obs_v[$];
    beat_t  drv;
    bit     drv_valid = 1'b0;
    bit     rand_ready = 1'b0;
    byte    key_b [PAT];
    logic [95:0] key_vec;
    int     n_assert = 0;
    int     n_fail   = 0;
    int     n_pkt    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t fill(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(byte'($urandom_range(128, 255)));
        return q;
    endfunction

    // Reference: does the key occur within the first nvalid symbols?
    function automatic bit ref_match(input bq_t s, input int nvalid, input bit en);
        bit ok;
        if (!en) return 1'b0;
        for (int i = 0; i + PAT <= nvalid; i++) begin
            ok = 1'b1;
            for (int k = 0; k < PAT; k++) if (s[i+k] != key_b[k]) ok = 1'b0;
            if (ok) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive inputs, check outputs, update the model, advance.
    task automatic do_cycle(output bit fired);
        beat_t f;
        bit    exp_rdy;
        bit    exp_rv;
        src_ready_i         = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        snk_valid_i         = drv_valid;
        snk_data_i          = drv.data;
        snk_startofpacket_i = drv.sop;
        snk_endofpacket_i   = drv.eop;
        snk_empty_i         = drv.empty;
        #2;
        exp_rdy = src_ready_i | (exp_q.size() == 0);
        check("snk_ready", 64'(snk_ready_o), 64'(exp_rdy));
        check("src_valid", 64'(src_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("src_data", src_data_o, f.data);
            check("src_sop", 64'(src_startofpacket_o), 64'(f.sop));
            check("src_eop", 64'(src_endofpacket_o), 64'(f.eop));
            check("src_empty", 64'(src_empty_o), 64'(f.empty));
            exp_rv = src_ready_i & f.eop & f.verdict;
            check("res_valid", 64'(res_valid_o), 64'(exp_rv));
            if (exp_rv) check("res_match", 64'(res_match_o), 64'(f.match));
            if (src_ready_i) void'(exp_q.pop_front());
        end else begin
            check("res_valid_idle", 64'(res_valid_o), 64'(0));
        end
        if (res_valid_o === 1'b1) obs_v.push_back(res_match_o);
        fired = drv_valid & exp_rdy;
        if (fired) exp_q.push_back(drv);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input beat_t bt);
        bit got = 1'b0;
        drv = bt;
        drv_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) do_cycle(got);
        check("sink_accept", 64'(got), 64'(1));
        drv_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bit g;
        for (int i = 0; i < n; i++) do_cycle(g);
    endtask

    task automatic send_packet(input bq_t s, input int empty, input bit en,
                               input bit drop_en, input bit want);
        int    nb     = s.size() / LANES;
        int    nvalid = s.size() - empty;
        bit    m      = ref_match(s, nvalid, en);
        beat_t bt;
        en_i      = en;
        pattern_i = key_vec;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < LANES; j++) bt.data[63-8*j -: 8] = s[b*LANES+j];
            bt.sop     = (b == 0);
            bt.eop     = (b == nb - 1);
            bt.empty   = bt.eop ? 3'(empty) : 3'd0;
            bt.verdict = bt.eop;
            bt.match   = m;
            if (rand_ready && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
            send_beat(bt);
            if (b == 0) begin
                if (drop_en) en_i = 1'b0;
                pattern_i = {$urandom, $urandom, $urandom};
            end
        end
        pattern_i = key_vec;
        exp_v.push_back(want);
        $display("pkt %0d: symbols=%0d empty=%0d en=%0b expected verdict=%0b",
                 n_pkt, nvalid, empty, en, want);
        n_pkt++;
    endtask

    task automatic drain_and_compare(input string tag);
        bit g;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) do_cycle(g);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        idle_cycles(2);
        check({tag, "_verdict_count"}, 64'(obs_v.size()), 64'(exp_v.size()));
        for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++)
            check({tag, "_verdict"}, 64'(obs_v[i]), 64'(exp_v[i]));
        obs_v.delete();
        exp_v.delete();
    endtask

    initial begin
        bq_t   s;
        beat_t bt;
        int    len, nb, off;

        for (int k = 0; k < PAT; k++) begin
            key_b[k] = byte'(k + 1);
            key_vec[95-8*k -: 8] = key_b[k];
        end
        drv.data = '0; drv.sop = 1'b0; drv.eop = 1'b0; drv.empty = '0;
        drv.verdict = 1'b0; drv.match = 1'b0;
        srst_n_i = 1'b0; en_i = 1'b1; pattern_i = key_vec; src_ready_i = 1'b1;
        snk_valid_i = 1'b0; snk_data_i = '0; snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0; snk_empty_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_src_valid", 64'(src_valid_o), 64'(0));
        check("rst_res_valid", 64'(res_valid_o), 64'(0));
        check("rst_res_match", 64'(res_match_o), 64'(0));
        check("rst_src_data", src_data_o, 64'(0));
        check("rst_src_flags", 64'({src_startofpacket_o, src_endofpacket_o, src_empty_o}), 64'(0));
        srst_n_i = 1'b1;
        idle_cycles(2);

        // Key spanning beats 0-2 of a 24-symbol packet
        s = fill(24);
        for (int k = 0; k < PAT; k++) s[5+k] = key_b[k];
        send_packet(s, 0, 1'b1, 1'b0, 1'b1);
        drain_and_compare("span");

        // Key split across two packets
        s = fill(24);
        for (int k = 0; k < 6; k++) s[12+k] = key_b[k];
        send_packet(s, 6, 1'b1, 1'b0, 1'b0);
        s = fill(16);
        for (int k = 0; k < 6; k++) s[k] = key_b[6+k];
        send_packet(s, 0, 1'b1, 1'b0, 1'b0);
        drain_and_compare("cross_pkt");

        // Key tail in empty lanes, then fully valid
        s = fill(24);
        for (int k = 0; k < PAT; k++) s[12+k] = key_b[k];
        send_packet(s, 4, 1'b1, 1'b0, 1'b0);
        send_packet(s, 0, 1'b1, 1'b0, 1'b1);
        drain_and_compare("empty");

        // Enable dropped mid-packet, then disabled packet
        s = fill(32);
        for (int k = 0; k < PAT; k++) s[10+k] = key_b[k];
        send_packet(s, 0, 1'b1, 1'b1, 1'b1);
        send_packet(s, 0, 1'b0, 1'b0, 1'b0);
        drain_and_compare("enable");

        // Short packets and an exactly key-sized packet
        s = fill(8);
        for (int k = 0; k < 8; k++) s[k] = key_b[k];
        send_packet(s, 0, 1'b1, 1'b0, 1'b0);
        send_packet(s, 3, 1'b1, 1'b0, 1'b0);
        s = fill(16);
        for (int k = 0; k < PAT; k++) s[k] = key_b[k];
        send_packet(s, 4, 1'b1, 1'b0, 1'b1);
        drain_and_compare("short");

        // Random backpressure, alternating key / no key
        rand_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(PAT, 40);
            nb  = (len + LANES - 1) / LANES;
            s   = fill(nb * LANES);
            if (p % 2 == 0) begin
                off = $urandom_range(0, len - PAT);
                for (int k = 0; k < PAT; k++) s[off+k] = key_b[k];
            end
            send_packet(s, nb * LANES - len, 1'b1, 1'b0, (p % 2 == 0));
        end
        drain_and_compare("random");
        rand_ready = 1'b0;

        // Reset in the middle of a packet
        s = fill(24);
        for (int k = 0; k < PAT; k++) s[2+k] = key_b[k];
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < LANES; j++) bt.data[63-8*j -: 8] = s[b*LANES+j];
            bt.sop = (b == 0); bt.eop = 1'b0; bt.empty = '0;
            bt.verdict = 1'b0; bt.match = 1'b0;
            send_beat(bt);
        end
        srst_n_i = 1'b0;
        idle_cycles(1);
        srst_n_i = 1'b1;
        exp_q.delete();
        check("midrst_src_valid", 64'(src_valid_o), 64'(0));
        check("midrst_src_data", src_data_o, 64'(0));
        check("midrst_res_match", 64'(res_match_o), 64'(0));
        check("midrst_res_valid", 64'(res_valid_o), 64'(0));
        // Stray EOP beat of the discarded packet: passes through, no verdict
        bt.data = {$urandom, $urandom}; bt.sop = 1'b0; bt.eop = 1'b1; bt.empty = 3'd2;
        bt.verdict = 1'b0; bt.match = 1'b0;
        send_beat(bt);
        s = fill(24);
        for (int k = 0; k < PAT; k++) s[7+k] = key_b[k];
        send_packet(s, 0, 1'b1, 1'b0, 1'b1);
        drain_and_compare("reset");
`ifdef SEARCH_MATCH_CNT_EN
        check("match_cnt", 64'(match_cnt_o), 64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
